// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag hunt, zero-unstuffing, abort detection and LSB-first octet assembly.
// Optional FCS (CRC-16/X.25) checking is compiled in with `define HDLCRX_FCS_CHECK_EN.
module hdlc_rx_deframer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       out_eof,
  output logic       out_err,
  output logic       out_abort,
  output logic       frame_active,
`ifdef HDLCRX_FCS_CHECK_EN
  output logic       fcs_ok,
`endif
  output logic [1:0] state_dbg
);

  // Handshake: bit_valid is a one-cycle strobe with no ready; out_valid/out_eof/out_abort
  // are one-cycle pulses the consumer must take on the cycle they appear (no backpressure).
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  ones_q, ones_d;
  logic [7:0]  acc_q, acc_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;

  logic        valid_d, sof_d, eof_d, err_d, abort_d;
  logic [7:0]  data_d;
  logic        aligned;

`ifdef HDLCRX_FCS_CHECK_EN
  logic [15:0] crc_q, crc_d;
  logic        fcs_d;
  logic        fcs_good;

  // Reflected CRC-16/X.25, one octet, data LSB first.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign fcs_good = (crc_q == 16'hF0B8) && (byte_cnt_q >= 8'd3) && aligned;
`endif

  // The first seven flag bits were shifted in as data, so a clean frame ends at bit_cnt 7.
  assign aligned      = (bit_cnt_q == 3'd7);
  assign frame_active = (state_q == DATA);
  assign state_dbg    = state_q;

  always_comb begin
    state_d    = state_q;
    ones_d     = ones_q;
    acc_d      = acc_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    err_d      = 1'b0;
    abort_d    = 1'b0;
    data_d     = out_data;
`ifdef HDLCRX_FCS_CHECK_EN
    crc_d      = crc_q;
    fcs_d      = 1'b0;
`endif
    if (bit_valid) begin
      if (bit_in) ones_d = (ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1;
      else        ones_d = 3'd0;

      if (bit_in && (ones_q >= 3'd6)) begin
        abort_d = (state_q == DATA);
        state_d = HUNT;
      end else if (!bit_in && (ones_q == 3'd6)) begin
        if ((state_q == DATA) && (byte_cnt_q != 8'd0)) begin
          eof_d = 1'b1;
`ifdef HDLCRX_FCS_CHECK_EN
          fcs_d = fcs_good;
          err_d = !aligned || !fcs_good;
`else
          err_d = !aligned;
`endif
        end
        state_d    = SYNC;
        acc_d      = 8'd0;
        bit_cnt_d  = 3'd0;
        byte_cnt_d = 8'd0;
`ifdef HDLCRX_FCS_CHECK_EN
        crc_d      = 16'hFFFF;
`endif
      end else if (!bit_in && (ones_q == 3'd5)) begin
        state_d = state_q;  // stuffed zero: dropped
      end else if (state_q != HUNT) begin
        acc_d     = {bit_in, acc_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          valid_d    = 1'b1;
          data_d     = acc_d;
          sof_d      = (byte_cnt_q == 8'd0);
          byte_cnt_d = (byte_cnt_q == 8'hFF) ? 8'hFF : byte_cnt_q + 8'd1;
          if (state_q == SYNC) state_d = DATA;
`ifdef HDLCRX_FCS_CHECK_EN
          crc_d = crc_byte(crc_q, acc_d);
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      ones_q     <= 3'd0;
      acc_q      <= 8'd0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 8'd0;
      out_valid  <= 1'b0;
      out_data   <= 8'd0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_err    <= 1'b0;
      out_abort  <= 1'b0;
`ifdef HDLCRX_FCS_CHECK_EN
      crc_q      <= 16'hFFFF;
      fcs_ok     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ones_q     <= ones_d;
      acc_q      <= acc_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      out_valid  <= valid_d;
      out_data   <= data_d;
      out_sof    <= sof_d;
      out_eof    <= eof_d;
      out_err    <= err_d;
      out_abort  <= abort_d;
`ifdef HDLCRX_FCS_CHECK_EN
      crc_q      <= crc_d;
      fcs_ok     <= fcs_d;
`endif
    end
  end

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Bench for hdlc_rx_deframer: transmit-side frame model predicts every output pulse per cycle,
// plus hand-computed literal checks on the decoded bytes, markers and debug state.
module tb_hdlc_rx_deframer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       out_valid, out_sof, out_eof, out_err, out_abort, frame_active;
  logic [7:0] out_data;
  logic [1:0] state_dbg;
`ifdef HDLCRX_FCS_CHECK_EN
  logic       fcs_ok;
`endif

  hdlc_rx_deframer dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof),
    .out_eof(out_eof), .out_err(out_err), .out_abort(out_abort),
    .frame_active(frame_active),
`ifdef HDLCRX_FCS_CHECK_EN
    .fcs_ok(fcs_ok),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    int         cyc;
    bit         is_byte;
    bit         is_eof;
    bit         is_abort;
    logic [7:0] data;
    bit         sof;
    bit         err;
    bit         fcs;
  } ev_t;
  ev_t exp_q[$];

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
  endtask

  // Transmit-side view of the link: what the receiver has been sent.
  localparam int K_DATA = 0, K_STUFF = 1, K_FLAG = 2, K_ONE = 3;
  bit          synced;
  int          tx_bytes;
  logic [7:0]  part;
  int          part_n;
  int          tx_run;
  logic [15:0] crc;
  bit          exp_active;
  logic [7:0]  last_data;
  int          gap;

  logic [7:0]  got_bytes[$];
  bit          got_sof[$];
  bit          eof_err[$];
  bit          eof_fcs[$];
  int          n_abort;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    repeat (8) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  task automatic model_clear();
    synced = 0; tx_bytes = 0; part = 8'h00; part_n = 0; tx_run = 0;
    crc = 16'hFFFF; exp_active = 0; last_data = 8'h00;
    exp_q.delete();
  endtask

  task automatic clear_logs();
    got_bytes.delete(); got_sof.delete(); eof_err.delete(); eof_fcs.delete(); n_abort = 0;
  endtask

  task automatic model_bit(input bit b, input int kind);
    ev_t e;
    tx_run = b ? tx_run + 1 : 0;
    e = '{default: 0};
    e.cyc = cyc;
    if (kind == K_ONE && tx_run >= 7) begin
      if (synced && tx_bytes > 0) begin
        e.is_abort = 1;
        exp_q.push_back(e);
      end
      synced = 0;
    end else if (kind == K_FLAG) begin
      if (synced && tx_bytes > 0) begin
        e.is_eof = 1;
        e.fcs = (crc == 16'hF0B8) && (tx_bytes >= 3) && (part_n == 7);
`ifdef HDLCRX_FCS_CHECK_EN
        e.err = (part_n != 7) || !e.fcs;
`else
        e.err = (part_n != 7);
        e.fcs = 0;
`endif
        exp_q.push_back(e);
      end
      synced = 1; tx_bytes = 0; part = 8'h00; part_n = 0; crc = 16'hFFFF;
    end else if (kind != K_STUFF && synced) begin
      part = {b, part[7:1]};
      part_n++;
      if (part_n == 8) begin
        e.is_byte = 1;
        e.data = part;
        e.sof = (tx_bytes == 0);
        exp_q.push_back(e);
        crc = crc_upd(crc, part);
        tx_bytes++;
        part_n = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_raw(input bit b, input int kind);
    idle(gap);
    bit_valid = 1'b1;
    bit_in = b;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    model_bit(b, kind);
  endtask

  task automatic send_data_bit(input bit b);
    send_raw(b, K_DATA);
    if (b && tx_run == 5) send_raw(1'b0, K_STUFF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_data_bit(b[i]);
  endtask

  task automatic send_flag();
    send_raw(1'b0, K_DATA);
    repeat (6) send_raw(1'b1, K_DATA);
    send_raw(1'b0, K_FLAG);
  endtask

  task automatic send_ones(input int n);
    repeat (n) send_raw(1'b1, K_ONE);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pulses"}, {out_valid, out_sof, out_eof, out_err, out_abort}, 5'b0);
    chk({tag, "_data"}, out_data, 8'h00);
    chk({tag, "_active"}, frame_active, 1'b0);
    chk({tag, "_state"}, state_dbg, 2'd0);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    ev_t e;
    logic [4:0] expv;
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("event_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      e = '{default: 0};
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) e = exp_q.pop_front();
      if (e.is_byte) begin last_data = e.data; exp_active = 1; end
      if (e.is_eof || e.is_abort) exp_active = 0;
      expv = {e.is_byte, e.is_byte & e.sof, e.is_eof, e.is_eof & e.err, e.is_abort};
      chk("pulses", {out_valid, out_sof, out_eof, out_err, out_abort}, expv);
      chk("out_data", out_data, last_data);
      chk("frame_active", frame_active, exp_active);
`ifdef HDLCRX_FCS_CHECK_EN
      chk("fcs_ok", fcs_ok, e.is_eof & e.fcs);
      if (out_eof) eof_fcs.push_back(fcs_ok);
`endif
      if (out_valid) begin got_bytes.push_back(out_data); got_sof.push_back(out_sof); end
      if (out_eof) eof_err.push_back(out_err);
      if (out_abort) n_abort++;
    end
  end

  // ---------------- directed stimulus ----------------
  logic [15:0] fcs;

  initial begin
    model_clear();
    clear_logs();
    gap = 0;
    #3;
    chk_all_zero("reset");
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // idle flags: sync only, no output
    send_flag();
    chk("state_after_first_flag", state_dbg, 2'd1);
    send_flag();
    send_flag();
    idle(2);
    chk("idle_no_bytes", got_bytes.size(), 0);
    chk("idle_no_eof", eof_err.size(), 0);
    chk("idle_active", frame_active, 1'b0);

    // stuffing removal: 7E and 3F each carry six ones
    clear_logs();
    send_byte(8'h7E); send_byte(8'h3F); send_byte(8'h00);
    send_flag();
    idle(2);
    chk("stuff_nbytes", got_bytes.size(), 3);
    chk("stuff_b0", got_bytes[0], 8'h7E);
    chk("stuff_b1", got_bytes[1], 8'h3F);
    chk("stuff_b2", got_bytes[2], 8'h00);
    chk("stuff_sof", {got_sof[0], got_sof[1], got_sof[2]}, 3'b100);
    chk("stuff_eof", eof_err.size(), 1);
    chk("stuff_err", eof_err[0], 1'b0);

    // good FCS frame, spaced bits
    gap = 1;
    clear_logs();
    fcs = ~crc_upd(crc_upd(crc_upd(16'hFFFF, 8'h01), 8'h02), 8'h03);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(fcs[7:0]); send_byte(fcs[15:8]);
    send_flag();
    idle(3);
    chk("fcs_nbytes", got_bytes.size(), 5);
    chk("fcs_b0", got_bytes[0], 8'h01);
    chk("fcs_b2", got_bytes[2], 8'h03);
    chk("fcs_err", eof_err[0], 1'b0);
`ifdef HDLCRX_FCS_CHECK_EN
    chk("fcs_ok_good", eof_fcs[0], 1'b1);
`endif

    // one flipped data bit, same FCS
    clear_logs();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h07);
    send_byte(fcs[7:0]); send_byte(fcs[15:8]);
    send_flag();
    idle(3);
    chk("badfcs_nbytes", got_bytes.size(), 5);
`ifdef HDLCRX_FCS_CHECK_EN
    chk("badfcs_err", eof_err[0], 1'b1);
    chk("badfcs_ok", eof_fcs[0], 1'b0);
`else
    chk("badfcs_err", eof_err[0], 1'b0);
`endif

    // misaligned: 3 extra bits + 5 flag bits form a second byte 0xF5
    gap = 0;
    clear_logs();
    send_byte(8'h55);
    send_data_bit(1'b1); send_data_bit(1'b0); send_data_bit(1'b1);
    send_flag();
    idle(2);
    chk("misal_nbytes", got_bytes.size(), 2);
    chk("misal_b0", got_bytes[0], 8'h55);
    chk("misal_b1", got_bytes[1], 8'hF5);
    chk("misal_err", eof_err[0], 1'b1);

    // abort mid-frame, then resync
    clear_logs();
    send_flag();
    send_byte(8'hA5);
    send_ones(8);
    idle(2);
    chk("abort_count", n_abort, 1);
    chk("abort_no_eof", eof_err.size(), 0);
    chk("abort_active", frame_active, 1'b0);
    chk("abort_state", state_dbg, 2'd0);
    send_flag();
    chk("resync_state", state_dbg, 2'd1);
    clear_logs();
    send_byte(8'h81);
    send_flag();
    idle(2);
    chk("resync_byte", got_bytes[0], 8'h81);
    chk("resync_err", eof_err[0], 1'b0);

    // asynchronous reset mid-byte
    gap = 2;
    send_byte(8'h5A);
    send_data_bit(1'b1); send_data_bit(1'b1); send_data_bit(1'b0);
    chk("pre_reset_active", frame_active, 1'b1);
    chk("pre_reset_data", out_data, 8'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    model_clear();
    idle(2);
    rst_n = 1'b1;
    gap = 0;
    clear_logs();
    send_flag();
    send_byte(8'hC3);
    send_flag();
    idle(2);
    chk("post_reset_nbytes", got_bytes.size(), 1);
    chk("post_reset_byte", got_bytes[0], 8'hC3);
    chk("post_reset_sof", got_sof[0], 1'b1);
    chk("post_reset_err", eof_err[0], 1'b0);

    idle(3);
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
